// File: rtl/memtrace_pkg.sv
// memtrace_pkg: shared widths and arbiter state encoding for the memory-trace issue path.
package memtrace_pkg;
    localparam int MEMTRACE_DATA_WIDTH  = 64;
    localparam int MEMTRACE_MAX_THREADS = 32;
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DRAIN     = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_DONE      = 2'd3
    } memtrace_arb_state_t;
endpackage

// File: rtl/memtrace_rr_pick.sv
// memtrace_rr_pick: combinational rotate-priority picker; grants the first pending lane at or after rr_ptr.
module memtrace_rr_pick #(
    parameter int NUM_THREADS = 4,
    parameter int TW          = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic [NUM_THREADS-1:0] pend,
    input  logic [TW-1:0]          rr_ptr,
    output logic                   grant_valid,
    output logic [TW-1:0]          grant_idx
);
    logic [TW-1:0] w_idx;
    // Walk offsets from the far end so the smallest offset from rr_ptr wins last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        w_idx       = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            w_idx = TW'((int'(rr_ptr) + i) % NUM_THREADS);
            if (pend[w_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = w_idx;
            end
        end
    end
endmodule

// File: rtl/memtrace_issue_arbiter.sv
// memtrace_issue_arbiter: captures trace batches and serializes lanes round-robin onto one credit-limited request port.
// Optional MEMTRACE_ARB_PERF_EN adds saturating 64-bit issue/stall counters.
module memtrace_issue_arbiter
    import memtrace_pkg::*;
#(
    parameter int NUM_THREADS     = 4,
    parameter int DATA_WIDTH      = MEMTRACE_DATA_WIDTH,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TW              = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                              clock,
    input  logic                              reset,
    output logic                              trace_read_ready,
    input  logic [NUM_THREADS-1:0]            trace_read_valid,
    input  logic [DATA_WIDTH*NUM_THREADS-1:0] trace_read_address,
    input  logic                              trace_read_finished,
    output logic                              mem_req_valid,
    input  logic                              mem_req_ready,
    output logic [DATA_WIDTH-1:0]             mem_req_addr,
    output logic [TW-1:0]                     mem_req_tid,
    input  logic                              mem_resp_valid,
    output logic                              done,
    output logic                              resp_underflow
`ifdef MEMTRACE_ARB_PERF_EN
    ,
    output logic [63:0]                       perf_issued,
    output logic [63:0]                       perf_stall_ready,
    output logic [63:0]                       perf_stall_credit
`endif
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    memtrace_arb_state_t                        r_state;
    logic [NUM_THREADS-1:0]                     r_pend;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]     r_addr;
    logic [CW-1:0]                              r_cnt;
    logic [TW-1:0]                              r_rr;
    logic                                       r_fin;
    logic                                       r_underflow;

    logic                   w_gv;
    logic [TW-1:0]          w_gidx;
    logic                   w_sel;
    logic                   w_full;
    logic                   w_acc;
    logic                   w_resp_ok;
    logic [NUM_THREADS-1:0] w_pend_nxt;

    memtrace_rr_pick #(.NUM_THREADS(NUM_THREADS), .TW(TW)) u_pick (
        .pend        (r_pend),
        .rr_ptr      (r_rr),
        .grant_valid (w_gv),
        .grant_idx   (w_gidx)
    );

    // Pick is a function of r_pend/r_rr only, so addr/tid hold until the accept.
    assign w_sel      = (r_state == ST_DRAIN) && w_gv;
    assign w_full     = (r_cnt == CW'(MAX_OUTSTANDING));
    assign w_acc      = mem_req_valid && mem_req_ready;
    assign w_resp_ok  = mem_resp_valid && (r_cnt != '0);
    assign w_pend_nxt = r_pend & ~(NUM_THREADS'(1) << w_gidx);

    assign trace_read_ready = (r_state == ST_IDLE);
    assign mem_req_valid    = w_sel && (!w_full || mem_resp_valid);
    assign mem_req_addr     = w_sel ? r_addr[w_gidx] : '0;
    assign mem_req_tid      = w_sel ? w_gidx : '0;
    assign done             = (r_state == ST_DONE);
    assign resp_underflow   = r_underflow;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pend      <= '0;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_rr        <= '0;
            r_fin       <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_cnt       <= r_cnt + CW'(w_acc) - CW'(w_resp_ok);
            r_underflow <= r_underflow | (mem_resp_valid && (r_cnt == '0));
            if (trace_read_finished && (r_state != ST_DONE))
                r_fin <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (|trace_read_valid) begin
                        r_pend  <= trace_read_valid;
                        r_addr  <= trace_read_address;
                        r_state <= ST_DRAIN;
                    end else if (r_fin) begin
                        r_state <= ST_WAIT_RESP;
                    end
                end
                ST_DRAIN: begin
                    if (w_acc) begin
                        r_pend <= w_pend_nxt;
                        r_rr   <= (w_gidx == TW'(NUM_THREADS - 1)) ? '0 : w_gidx + 1'b1;
                        if (w_pend_nxt == '0)
                            r_state <= ST_IDLE;
                    end
                end
                ST_WAIT_RESP: r_state <= (r_cnt == '0) ? ST_DONE : ST_WAIT_RESP;
                default:      r_state <= ST_DONE;
            endcase
        end
    end

`ifdef MEMTRACE_ARB_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_issued       <= '0;
            perf_stall_ready  <= '0;
            perf_stall_credit <= '0;
        end else begin
            if (w_acc && !(&perf_issued))
                perf_issued <= perf_issued + 64'd1;
            if (mem_req_valid && !mem_req_ready && !(&perf_stall_ready))
                perf_stall_ready <= perf_stall_ready + 64'd1;
            if (w_sel && w_full && !mem_resp_valid && !(&perf_stall_credit))
                perf_stall_credit <= perf_stall_credit + 64'd1;
        end
    end
`endif
endmodule

// File: tb/tb_memtrace_issue_arbiter.sv
// tb_memtrace_issue_arbiter: scoreboard bench; expected requests queued at stimulus time, compared on each accept.
module tb_memtrace_issue_arbiter;
    localparam int NT = 4;
    localparam int DW = 64;
    localparam int MO = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             trace_read_ready;
    logic [NT-1:0]    trace_read_valid = '0;
    logic [DW*NT-1:0] trace_read_address = '0;
    logic             trace_read_finished = 1'b0;
    logic             mem_req_valid;
    logic             mem_req_ready = 1'b0;
    logic [DW-1:0]    mem_req_addr;
    logic [1:0]       mem_req_tid;
    logic             mem_resp_valid = 1'b0;
    logic             done;
    logic             resp_underflow;

    logic [127:0] q[$];
    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;
    int acc0;

    memtrace_issue_arbiter #(.NUM_THREADS(NT), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
        .clock               (clock),
        .reset               (reset),
        .trace_read_ready    (trace_read_ready),
        .trace_read_valid    (trace_read_valid),
        .trace_read_address  (trace_read_address),
        .trace_read_finished (trace_read_finished),
        .mem_req_valid       (mem_req_valid),
        .mem_req_ready       (mem_req_ready),
        .mem_req_addr        (mem_req_addr),
        .mem_req_tid         (mem_req_tid),
        .mem_resp_valid      (mem_resp_valid),
        .done                (done),
        .resp_underflow      (resp_underflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    function automatic logic [63:0] lane_addr(input int t, input logic [63:0] base);
        return base + 64'(t + 1) * 64'h100;
    endfunction

    task automatic batch(input logic [NT-1:0] v, input logic [63:0] base);
        trace_read_valid = v;
        for (int g = 0; g < NT; g++)
            trace_read_address[DW*g +: DW] = lane_addr(g, base);
    endtask

    task automatic exp_req(input int t, input logic [63:0] base);
        q.push_back({64'(t), lane_addr(t, base)});
    endtask

    task automatic check_rst(input string tag);
        check({tag, "_rdy"}, 128'(trace_read_ready), 128'd1);
        check({tag, "_vld"}, 128'(mem_req_valid), 128'd0);
        check({tag, "_addr"}, 128'(mem_req_addr), 128'd0);
        check({tag, "_tid"}, 128'(mem_req_tid), 128'd0);
        check({tag, "_done"}, 128'(done), 128'd0);
        check({tag, "_uflow"}, 128'(resp_underflow), 128'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        trace_read_valid = '0;
        trace_read_finished = 1'b0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        nxt();
        reset = 1'b0;
        smp();
    endtask

    always @(negedge clock) begin
        if (!reset && mem_req_valid && mem_req_ready) begin
            n_acc++;
            if (q.size() == 0)
                check("sb_unexpected", {64'(mem_req_tid), mem_req_addr}, 128'd0);
            else
                check("sb_req", {64'(mem_req_tid), mem_req_addr}, q.pop_front());
        end
    end

    initial begin
        do_reset();
        check_rst("rst");

        // single batch 1011; third request needs a same-cycle response at cnt==MO
        nxt(); batch(4'b1011, 64'h0); mem_req_ready = 1'b1;
        exp_req(0, 64'h0); exp_req(1, 64'h0); exp_req(3, 64'h0);
        smp(); check("t1_rdy_capture", 128'(trace_read_ready), 128'd1);
        nxt(); trace_read_valid = '0;
        smp(); check("t1_rdy_b", 128'(trace_read_ready), 128'd0);
        check("t1_vld_first", 128'(mem_req_valid), 128'd1);
        nxt(); smp(); check("t1_rdy_c", 128'(trace_read_ready), 128'd0);
        nxt(); mem_resp_valid = 1'b1;
        smp(); check("t1_rdy_d", 128'(trace_read_ready), 128'd0);
        check("t1_bypass_vld", 128'(mem_req_valid), 128'd1);
        nxt(); mem_resp_valid = 1'b0;
        smp(); check("t1_rdy_back", 128'(trace_read_ready), 128'd1);

        // credit limit: four lanes, no responses, only two issue
        do_reset();
        nxt(); batch(4'b1111, 64'h1000); mem_req_ready = 1'b1;
        exp_req(0, 64'h1000); exp_req(1, 64'h1000);
        acc0 = n_acc;
        smp();
        nxt(); trace_read_valid = '0; smp();
        nxt(); smp();
        nxt(); smp(); check("cr_block0", 128'(mem_req_valid), 128'd0);
        nxt(); smp(); check("cr_block1", 128'(mem_req_valid), 128'd0);
        check("cr_issued", 128'(n_acc - acc0), 128'd2);
        exp_req(2, 64'h1000);
        nxt(); mem_resp_valid = 1'b1;
        smp(); check("cr_bypass", 128'(mem_req_valid), 128'd1);
        nxt(); mem_resp_valid = 1'b0;
        smp(); check("cr_hold", 128'(mem_req_valid), 128'd0);
        check("cr_issued3", 128'(n_acc - acc0), 128'd3);

        // backpressure: ready low for 5 cycles, request held stable
        do_reset();
        nxt(); batch(4'b0110, 64'h2000); smp();
        nxt(); trace_read_valid = '0;
        for (int k = 0; k < 5; k++) begin
            smp();
            check("bp_vld", 128'(mem_req_valid), 128'd1);
            check("bp_addr", 128'(mem_req_addr), 128'h2200);
            check("bp_tid", 128'(mem_req_tid), 128'd1);
            nxt();
        end
        exp_req(1, 64'h2000); exp_req(2, 64'h2000);
        mem_req_ready = 1'b1;
        smp();
        nxt(); smp();
        nxt(); smp(); check("bp_rdy_back", 128'(trace_read_ready), 128'd1);

        // round-robin carry-over: 0011 leaves rr_ptr=2, then 1111 issues 2,3,0,1
        do_reset();
        nxt(); batch(4'b0011, 64'h3000); mem_req_ready = 1'b1;
        exp_req(0, 64'h3000); exp_req(1, 64'h3000);
        smp();
        nxt(); trace_read_valid = '0; smp();
        nxt(); smp();
        nxt(); batch(4'b1111, 64'h4000);
        exp_req(2, 64'h4000); exp_req(3, 64'h4000); exp_req(0, 64'h4000); exp_req(1, 64'h4000);
        smp(); check("rr_rdy_capture", 128'(trace_read_ready), 128'd1);
        nxt(); trace_read_valid = '0; mem_resp_valid = 1'b1; smp();
        for (int k = 0; k < 3; k++) begin
            nxt(); smp();
        end
        nxt(); mem_resp_valid = 1'b0;
        smp(); check("rr_rdy_back", 128'(trace_read_ready), 128'd1);

        // reset mid-DRAIN with two lanes pending, then a fresh batch
        do_reset();
        nxt(); batch(4'b1111, 64'h5000); mem_req_ready = 1'b1;
        exp_req(0, 64'h5000); exp_req(1, 64'h5000);
        smp();
        nxt(); trace_read_valid = '0; smp();
        nxt(); smp();
        nxt(); smp(); check("mr_stalled", 128'(trace_read_ready), 128'd0);
        nxt(); reset = 1'b1; smp();
        nxt(); reset = 1'b0; smp();
        check_rst("mr");
        nxt(); batch(4'b0100, 64'h6000); exp_req(2, 64'h6000); smp();
        nxt(); trace_read_valid = '0; smp();
        nxt(); smp(); check("mr_rdy_back", 128'(trace_read_ready), 128'd1);

        // completion and underflow
        do_reset();
        nxt(); batch(4'b0001, 64'h8000); trace_read_finished = 1'b1; mem_req_ready = 1'b1;
        exp_req(0, 64'h8000);
        smp();
        nxt(); trace_read_valid = '0; trace_read_finished = 1'b0; smp();
        nxt(); smp(); check("cp_idle_rdy", 128'(trace_read_ready), 128'd1);
        nxt(); smp(); check("cp_wait_rdy", 128'(trace_read_ready), 128'd0);
        check("cp_wait_done", 128'(done), 128'd0);
        nxt(); mem_resp_valid = 1'b1;
        smp(); check("cp_resp_done", 128'(done), 128'd0);
        nxt(); mem_resp_valid = 1'b0;
        smp(); check("cp_zero_done", 128'(done), 128'd0);
        nxt(); smp(); check("cp_done", 128'(done), 128'd1);
        check("cp_no_uflow", 128'(resp_underflow), 128'd0);
        nxt(); mem_resp_valid = 1'b1; smp();
        nxt(); mem_resp_valid = 1'b0;
        smp(); check("cp_uflow", 128'(resp_underflow), 128'd1);
        check("cp_done_held", 128'(done), 128'd1);
        check("cp_done_rdy", 128'(trace_read_ready), 128'd0);

        check("sb_leftover", 128'(q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
